vscale_md_unit: RTL

//  Iterative multiply/divide unit sitting beside the ALU in the DX stage. Same rs1/rs2

---
 rtl/vscale_md_unit_pkg.sv | 35 +++
 rtl/vscale_md_unit.sv | 136 +++++++++++++
 2 files changed

// File: rtl/vscale_md_unit_pkg.sv
// Shared constants, state encoding and request record for the RV32M multiply/divide unit.
package vscale_md_unit_pkg;

  localparam int XPR_LEN     = 32;
  localparam int MD_ITERS    = 32;
  localparam int MD_CNT_W    = $clog2(MD_ITERS);
  localparam int MD_OP_WIDTH = 2;

  localparam logic [MD_OP_WIDTH-1:0] MD_OP_MUL = 2'd0;
  localparam logic [MD_OP_WIDTH-1:0] MD_OP_DIV = 2'd1;
  localparam logic [MD_OP_WIDTH-1:0] MD_OP_REM = 2'd2;

  localparam logic MD_OUT_LO = 1'b0;
  localparam logic MD_OUT_HI = 1'b1;

  typedef enum logic [1:0] {
    MD_IDLE    = 2'd0,
    MD_SETUP   = 2'd1,
    MD_COMPUTE = 2'd2,
    MD_FINISH  = 2'd3
  } md_state_t;

  typedef struct packed {
    logic [MD_OP_WIDTH-1:0] op;
    logic                   out_sel;
    logic                   in_1_signed;
    logic                   in_2_signed;
  } md_req_t;

  function automatic logic [XPR_LEN-1:0] md_abs(input logic [XPR_LEN-1:0] v,
                                                input logic is_signed);
    return (is_signed && v[XPR_LEN-1]) ? -v : v;
  endfunction

endpackage

// File: rtl/vscale_md_unit.sv
// Iterative RV32M multiply/divide: one shift-add or restoring-divide step per cycle,
// operating on magnitudes with the sign fixed up on the way into FINISH.
module vscale_md_unit
  import vscale_md_unit_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [MD_OP_WIDTH-1:0] req_op,
  input  logic                   req_out_sel,
  input  logic                   req_in_1_signed,
  input  logic                   req_in_2_signed,
  input  logic [XPR_LEN-1:0]     req_in_1,
  input  logic [XPR_LEN-1:0]     req_in_2,
  input  logic                   kill,
  output logic                   resp_valid,
  output logic [XPR_LEN-1:0]     resp_result
);

  localparam logic [MD_CNT_W-1:0] CNT_LAST = MD_CNT_W'(MD_ITERS - 1);

  md_state_t              state;
  md_req_t                req_q;
  logic [XPR_LEN-1:0]     a_q, b_q;
  logic [2*XPR_LEN-1:0]   acc_q;
  logic [XPR_LEN:0]       rem_q;
  logic [MD_CNT_W-1:0]    cnt_q;
  logic                   negate_q, div_zero_q;

  logic                   is_mul, sign_1, sign_2;
  logic [XPR_LEN-1:0]     abs_1, abs_2;
  logic [XPR_LEN:0]       mul_sum;
  logic [XPR_LEN+1:0]     diff;
  logic [2*XPR_LEN-1:0]   acc_step, prod_fin;
  logic [XPR_LEN:0]       rem_step;
  logic [XPR_LEN-1:0]     quo_fin, rem_fin, result_fin;

  always_comb begin
    is_mul  = (req_q.op == MD_OP_MUL);
    sign_1  = req_q.in_1_signed & a_q[XPR_LEN-1];
    sign_2  = req_q.in_2_signed & b_q[XPR_LEN-1];
    abs_1   = md_abs(a_q, req_q.in_1_signed);
    abs_2   = md_abs(b_q, req_q.in_2_signed);
    // MUL: acc = {partial product, remaining multiplier bits}
    mul_sum = {1'b0, acc_q[2*XPR_LEN-1:XPR_LEN]} + (acc_q[0] ? {1'b0, a_q} : '0);
    // DIV: acc[XPR_LEN-1:0] shifts dividend bits out and quotient bits in
    diff    = {rem_q, acc_q[XPR_LEN-1]} - {2'b00, b_q};
    acc_step = acc_q;
    rem_step = rem_q;
    if (is_mul) begin
      acc_step = {mul_sum, acc_q[XPR_LEN-1:1]};
    end else begin
      acc_step = {acc_q[2*XPR_LEN-1:XPR_LEN], acc_q[XPR_LEN-2:0], ~diff[XPR_LEN+1]};
      rem_step = diff[XPR_LEN+1] ? {rem_q[XPR_LEN-1:0], acc_q[XPR_LEN-1]} : diff[XPR_LEN:0];
    end
    prod_fin = negate_q ? -acc_step : acc_step;
    // a zero divisor leaves all-ones in the quotient, which must not be negated
    quo_fin  = (negate_q && !div_zero_q) ? -acc_step[XPR_LEN-1:0] : acc_step[XPR_LEN-1:0];
    rem_fin  = negate_q ? -rem_step[XPR_LEN-1:0] : rem_step[XPR_LEN-1:0];
    case (req_q.op)
      MD_OP_MUL: result_fin = (req_q.out_sel == MD_OUT_HI) ? prod_fin[2*XPR_LEN-1:XPR_LEN]
                                                           : prod_fin[XPR_LEN-1:0];
      MD_OP_DIV: result_fin = quo_fin;
      default:   result_fin = rem_fin;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= MD_IDLE;
      req_ready   <= 1'b1;
      resp_valid  <= 1'b0;
      resp_result <= '0;
      req_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      rem_q       <= '0;
      cnt_q       <= '0;
      negate_q    <= 1'b0;
      div_zero_q  <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        MD_IDLE: begin
          if (req_valid && !kill) begin
            state             <= MD_SETUP;
            req_ready         <= 1'b0;
            req_q.op          <= req_op;
            req_q.out_sel     <= req_out_sel;
            req_q.in_1_signed <= req_in_1_signed;
            req_q.in_2_signed <= req_in_2_signed;
            a_q               <= req_in_1;
            b_q               <= req_in_2;
          end
        end
        MD_SETUP: begin
          if (kill) begin
            state     <= MD_IDLE;
            req_ready <= 1'b1;
          end else begin
            state      <= MD_COMPUTE;
            a_q        <= abs_1;
            b_q        <= abs_2;
            negate_q   <= (req_q.op == MD_OP_REM) ? sign_1 : (sign_1 ^ sign_2);
            div_zero_q <= (b_q == '0);
            acc_q      <= {{XPR_LEN{1'b0}}, is_mul ? abs_2 : abs_1};
            rem_q      <= '0;
            cnt_q      <= '0;
          end
        end
        MD_COMPUTE: begin
          if (kill) begin
            state     <= MD_IDLE;
            req_ready <= 1'b1;
          end else begin
            acc_q <= acc_step;
            rem_q <= rem_step;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
              state       <= MD_FINISH;
              resp_valid  <= 1'b1;
              resp_result <= result_fin;
            end
          end
        end
        default: begin
          state     <= MD_IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
